// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver/transmitter pair:
//   - uart_state_e  : 2-bit frame-state encoding (idle, start, data, stop)
//   - calc_baud_cnt : clocks per bit, CLK_FREQ / BAUD_RATE
//   - calc_half     : clocks to the middle of a bit, BAUD_CNT / 2
//   - params_ok     : legal-range check for the frame/baud parameters
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    function automatic int unsigned calc_baud_cnt(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned calc_half(input int unsigned baud_cnt);
        return baud_cnt / 2;
    endfunction

    function automatic bit params_ok(input int unsigned clk_freq,
                                     input int unsigned baud_rate,
                                     input int unsigned data_width,
                                     input int unsigned stop_width);
        int unsigned bc;
        if (baud_rate == 0) return 1'b0;
        bc = clk_freq / baud_rate;
        return (bc >= 4) && (bc <= 65535) &&
               (data_width >= 5) && (data_width <= 8) &&
               (stop_width >= 1) && (stop_width <= 2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous rxd pin plus a delayed copy for
// falling-edge detection.
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous active-high reset (all flops to 1 = idle line)
//   i_rxd   - raw serial pin
//   o_rx_s  - synchronised line level (2 cycles of latency)
//   o_fall  - high for one cycle when o_rx_s goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxd,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_dly  <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_dly & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver: start bit, DATA_WIDTH data bits LSB first,
// STOP_WIDTH stop bits, idle-high line. Each bit is sampled at mid-period.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rxd       - serial line from the pin (asynchronous)
//   data_rx   - last good word; bits above DATA_WIDTH-1 read 0
//   rx_done   - one-cycle pulse: data_rx updated with a good frame
//   frame_err - one-cycle pulse: a stop bit sampled 0, data_rx held
//   busy      - high from start-edge detect until the frame ends or is rejected
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_rx,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF     = calc_half(BAUD_CNT);

    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_WIDTH - 1);

    if (!params_ok(CLK_FREQ, BAUD_RATE, DATA_WIDTH, STOP_WIDTH)) begin : g_bad_params
        $error("uart_rx: parameters out of range");
    end

    logic w_rx_s;
    logic w_fall;

    uart_rx_sync u_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_rxd  (rxd),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    uart_state_e r_state,   w_state_d;
    logic [15:0] r_br_cnt,  w_br_cnt_d;
    logic [3:0]  r_bit_cnt, w_bit_cnt_d;
    logic [7:0]  r_shift,   w_shift_d;
    logic        r_err,     w_err_d;
    logic        r_busy,    w_busy_d;
    logic [7:0]  r_data,    w_data_d;
    logic        r_done,    w_done_d;
    logic        r_ferr,    w_ferr_d;
    logic        w_stop_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_br_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_br_cnt  <= w_br_cnt_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
            r_err     <= w_err_d;
            r_busy    <= w_busy_d;
            r_data    <= w_data_d;
            r_done    <= w_done_d;
            r_ferr    <= w_ferr_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_br_cnt_d  = r_br_cnt;
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_err_d     = r_err;
        w_busy_d    = r_busy;
        w_data_d    = r_data;
        w_done_d    = 1'b0;
        w_ferr_d    = 1'b0;
        // Includes the sample being taken this cycle, so the verdict is ready
        // on the last stop bit without waiting for r_err to update.
        w_stop_bad  = r_err | ~w_rx_s;

        unique case (r_state)
            StIdle: begin
                // Edge, not level: a line stuck low cannot re-trigger.
                if (w_fall) begin
                    w_state_d  = StStart;
                    w_busy_d   = 1'b1;
                    w_br_cnt_d = '0;
                    w_err_d    = 1'b0;
                end
            end
            StStart: begin
                if (r_br_cnt == HALF_LAST) begin
                    if (w_rx_s) begin
                        // Line back high at mid-start: glitch, drop it.
                        w_state_d = StIdle;
                        w_busy_d  = 1'b0;
                    end else begin
                        w_state_d   = StData;
                        w_br_cnt_d  = '0;
                        w_bit_cnt_d = '0;
                    end
                end else begin
                    w_br_cnt_d = r_br_cnt + 16'd1;
                end
            end
            StData: begin
                if (r_br_cnt == BAUD_LAST) begin
                    w_shift_d[r_bit_cnt[2:0]] = w_rx_s;
                    w_br_cnt_d = '0;
                    if (r_bit_cnt == DATA_LAST) begin
                        w_state_d   = StStop;
                        w_bit_cnt_d = '0;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_br_cnt_d = r_br_cnt + 16'd1;
                end
            end
            StStop: begin
                if (r_br_cnt == BAUD_LAST) begin
                    w_br_cnt_d = '0;
                    w_err_d    = w_stop_bad;
                    if (r_bit_cnt == STOP_LAST) begin
                        // Leaving at mid-stop leaves half a bit to catch the
                        // next start edge at full line rate.
                        w_state_d   = StIdle;
                        w_busy_d    = 1'b0;
                        w_bit_cnt_d = '0;
                        if (w_stop_bad) begin
                            w_ferr_d = 1'b1;
                        end else begin
                            w_done_d = 1'b1;
                            w_data_d = r_shift;
                        end
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_br_cnt_d = r_br_cnt + 16'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    assign data_rx   = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at BAUD_CNT=16, HALF=8. Instance u_dut is 8N1;
// instance u_dut7 is 7 data / 2 stop and is fed by a bench-side transmitter.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int unsigned CLK_FREQ  = 1_600_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int          BAUD      = 16;
    localparam int          LAT       = 155;  // rxd drive -> pulse: 2 sync + 8 + 9*16 + 1

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data_rx;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    logic       rxd7;
    logic [7:0] data_rx7;
    logic       rx_done7;
    logic       frame_err7;
    logic       busy7;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_WIDTH (8),
        .STOP_WIDTH (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data_rx   (data_rx),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_WIDTH (7),
        .STOP_WIDTH (2)
    ) u_dut7 (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd7),
        .data_rx   (data_rx7),
        .rx_done   (rx_done7),
        .frame_err (frame_err7),
        .busy      (busy7)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[5];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         c0;
    int         busy_cnt = 0;
    int         both_cnt = 0;
    int         done_q[$];
    logic [7:0] data_q[$];
    int         err_q[$];
    logic [7:0] exp7_q[$];
    int         done7_cnt = 0;
    int         err7_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (rx_done) begin
            done_q.push_back(cyc);
            data_q.push_back(data_rx);
        end
        if (frame_err) err_q.push_back(cyc);
        if (rx_done && frame_err) both_cnt++;
        if (frame_err7) err7_cnt++;
        if (rx_done7) begin
            done7_cnt++;
            if (exp7_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL loop_extra: got 0x%0h expected no pulse", data_rx7);
            end else begin
                check("loop_data", {24'd0, data_rx7}, {24'd0, exp7_q.pop_front()});
            end
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clear();
        done_q.delete();
        data_q.delete();
        err_q.delete();
        busy_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BAUD) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    // Transmitter model for the 7-data / 2-stop instance.
    task automatic send_frame7(input logic [7:0] d);
        rxd7 = 1'b0;
        repeat (BAUD) tick();
        for (int i = 0; i < 7; i++) begin
            rxd7 = d[i];
            repeat (BAUD) tick();
        end
        rxd7 = 1'b1;
        repeat (2 * BAUD) tick();
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (q.size() > idx) ? q[idx] : -1;
    endfunction

    initial begin
        logic [7:0] b;

        vecs[0] = '{data: 8'h3C, stop: 1'b1, exp_done: 1, exp_err: 0, exp_data: 8'h3C};
        vecs[1] = '{data: 8'h55, stop: 1'b0, exp_done: 0, exp_err: 1, exp_data: 8'h3C};
        vecs[2] = '{data: 8'h81, stop: 1'b1, exp_done: 1, exp_err: 0, exp_data: 8'h81};
        vecs[3] = '{data: 8'h7E, stop: 1'b1, exp_done: 1, exp_err: 0, exp_data: 8'h7E};
        vecs[4] = '{data: 8'h01, stop: 1'b0, exp_done: 0, exp_err: 1, exp_data: 8'h7E};

        // Reset
        rst  = 1'b1;
        rxd  = 1'b1;
        rxd7 = 1'b1;
        repeat (3) tick();
        check("rst_data", {24'd0, data_rx}, 32'h0);
        check("rst_done", {31'd0, rx_done}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        idle(10);

        // 1: single 0xA5 frame, exact latency and busy window
        clear();
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("t1_ndone", done_q.size(), 1);
        check("t1_lat", q_at(done_q, 0) - c0, LAT);
        check("t1_data", {24'd0, data_rx}, 32'hA5);
        check("t1_nerr", err_q.size(), 0);
        check("t1_busy", busy_cnt, LAT - 3);

        // 2: back-to-back 0x00, 0xFF
        clear();
        c0 = cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("t2_ndone", done_q.size(), 2);
        check("t2_lat", q_at(done_q, 0) - c0, LAT);
        check("t2_gap", q_at(done_q, 1) - q_at(done_q, 0), 10 * BAUD);
        check("t2_d0", {24'd0, (data_q.size() > 0) ? data_q[0] : 8'hxx}, 32'h00);
        check("t2_d1", {24'd0, (data_q.size() > 1) ? data_q[1] : 8'hxx}, 32'hFF);
        check("t2_nerr", err_q.size(), 0);

        // 3: 4-cycle low glitch
        clear();
        rxd = 1'b0;
        repeat (4) tick();
        idle(30);
        check("t3_busy", busy_cnt, 8);
        check("t3_ndone", done_q.size(), 0);
        check("t3_nerr", err_q.size(), 0);
        check("t3_data", {24'd0, data_rx}, 32'hFF);

        // Table: good frames and forced-zero stop bits
        for (int v = 0; v < 5; v++) begin
            clear();
            c0 = cyc;
            send_frame(vecs[v].data, vecs[v].stop);
            idle(20);
            check($sformatf("vec%0d_ndone", v), done_q.size(), vecs[v].exp_done);
            check($sformatf("vec%0d_nerr", v), err_q.size(), vecs[v].exp_err);
            check($sformatf("vec%0d_data", v), {24'd0, data_rx}, {24'd0, vecs[v].exp_data});
            if (vecs[v].exp_err != 0)
                check($sformatf("vec%0d_errlat", v), q_at(err_q, 0) - c0, LAT);
        end

        // 4: bad stop, then line held low: no retrigger until a fresh edge
        clear();
        send_frame(8'h55, 1'b0);
        rxd = 1'b0;
        busy_cnt = 0;
        repeat (100) tick();
        check("t4_nerr", err_q.size(), 1);
        check("t4_ndone", done_q.size(), 0);
        check("t4_busy_low", busy_cnt, 0);
        check("t4_data", {24'd0, data_rx}, 32'h7E);
        idle(20);
        clear();
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("t4_after", {24'd0, data_rx}, 32'h3C);
        check("t4_after_n", done_q.size(), 1);

        // 5: reset mid-DATA of 0x81
        clear();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t5_busy_mid", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        rxd = 1'b1;
        tick();
        check("t5_rst_data", {24'd0, data_rx}, 32'h0);
        check("t5_rst_busy", {31'd0, busy}, 32'h0);
        check("t5_rst_done", {31'd0, rx_done}, 32'h0);
        check("t5_rst_ferr", {31'd0, frame_err}, 32'h0);
        rst = 1'b0;
        clear();
        idle(200);
        check("t5_quiet", done_q.size() + err_q.size() + busy_cnt, 0);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("t5_ndone", done_q.size(), 1);
        check("t5_data", {24'd0, data_rx}, 32'h81);

        // 6: 7-data / 2-stop loopback, 256 random bytes back to back
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom_range(0, 255));
            exp7_q.push_back(b & 8'h7F);
            send_frame7(b);
        end
        repeat (40) tick();
        check("t6_ndone", done7_cnt, 256);
        check("t6_nerr", err7_cnt, 0);
        check("t6_left", exp7_q.size(), 0);

        check("excl_pulses", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
